data_mem_unit: RTL
==================

# data_mem_unit

Data-memory responder for the DM stage of the pipelined core. Consumes the memory request held in the EX/DM pipeline register (read/write strobes, byte address, store data), performs a word access on an internal memory array after a parameterised wait time, and returns load data. While an access is in flight it asserts `stall`, which freezes the EX/DM register and all earlier stages.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, 16..4096.
- `LATENCY`, default 2: number of BUSY wait cycles per access, range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_read_in`  in  1  load request, from the EX/DM register.
- `mem_write_in`  in  1  store request, from the EX/DM register.
- `Mem_address`  in  32  byte address, from the EX/DM register.
- `Write_data_in`  in  32  store data, from the EX/DM register.
- `Read_data`  out  32  load result; holds until the next load completes.
- `read_valid`  out  1  high for exactly the DONE cycle of a load.
- `stall`  out  1  high while a request is pending; freezes the upstream pipeline.
- `addr_error`  out  1  high while an illegal request is presented in IDLE.

## Operation
- States: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` runs in BUSY.
- `req` = `mem_read_in | mem_write_in`.
- `bad` = `Mem_address[1:0] != 0`, or word index `Mem_address[31:2] >= DEPTH_WORDS`.
- IDLE:
  - `req & ~bad`: latch address, data and op. Next state BUSY with `cnt = LATENCY-1`.
  - `req & bad`: `addr_error=1`, `stall=0`. Request dropped; no array access; stay in IDLE.
  - `~req`: stay in IDLE.
- BUSY: if `cnt != 0`, decrement. If `cnt == 0`, go to DONE and perform the access at that edge:
  - Store: `mem[idx] <= latched data`.
  - Load: `Read_data <= mem[idx]`.
- DONE: drive `read_valid=1` for a load only. Go to IDLE unconditionally. The upstream register advances at this edge, so the same request is never re-accepted.
- `stall = (IDLE & req & ~bad) | BUSY`. It is combinational, so the request cycle itself is stalled.
- `idx = Mem_address[log2(DEPTH_WORDS)+1:2]` (latched copy).
- If both strobes are high, the access is a store. No `read_valid`, and `Read_data` is unchanged.
- Inputs are ignored outside IDLE. All accesses use the latched copies.

## Timing
- Request first visible in cycle 0 (IDLE):
  - Stall cycles: 0..`LATENCY`, i.e. `LATENCY+1` cycles.
  - DONE is cycle `LATENCY+1`, with `stall=0`.
  - `Read_data` is valid from cycle `LATENCY+1` onward.
- Back-to-back requests: the next request is presented in the cycle after DONE (IDLE). Minimum issue interval is `LATENCY+2` cycles.
- Reset values: state IDLE, `cnt=0`, `Read_data=0`, `read_valid=0`, latched registers 0. `stall` and `addr_error` follow the inputs (0 when there is no request).
- Reset asserted mid-BUSY or in DONE:
  - Immediate return to IDLE.
  - A pending store is aborted and not committed.
  - A pending load leaves `Read_data` at 0.
- The memory array is not cleared by reset. Simulation initialises it to 0.

## Test plan
- Store/load round trip, `LATENCY=2`: store `0xDEADBEEF` to address `0x10`, then load `0x10`.
  - `stall` is high for 3 cycles on each request.
  - The load's DONE cycle shows `read_valid=1` and `Read_data=0xDEADBEEF`.
  - `read_valid` stays 0 on the store's DONE cycle.
- Misaligned load at `0x13`: `addr_error=1`, `stall=0`, state stays IDLE, `Read_data` unchanged.
- Out-of-range store at `0x400` with `DEPTH_WORDS=256`:
  - `addr_error=1`, no stall.
  - A following load of `0x0` returns the old contents.
- Reset pulled low in the second BUSY cycle of a store to `0x20` (value `0x12345678`):
  - Outputs return to reset values.
  - A later load of `0x20` returns 0.
- Both strobes high, address `0x8`, data `0xA5A5A5A5`:
  - Treated as a store; no `read_valid`.
  - A subsequent load of `0x8` returns `0xA5A5A5A5`.
- `LATENCY=1`, loads from `0x0` and `0x4` held back-to-back, presented in the cycle after DONE: stall pattern 1,1,0 per request, with issue interval 3 cycles.

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: DM-stage data memory responder.
// Accepts a load/store from the EX/DM register, waits LATENCY busy cycles,
// performs a single word access on an internal array and returns load data.
// Ports:
//   clk, reset (async, active-low)
//   mem_read_in, mem_write_in, Mem_address, Write_data_in : request from EX/DM
//   Read_data   : last load result, held until the next load completes
//   read_valid  : high for the DONE cycle of a load
//   stall       : combinational; freezes the upstream pipeline while pending
//   addr_error  : combinational; illegal request presented while idle
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] Mem_address,
    input  logic [31:0] Write_data_in,
    output logic [31:0] Read_data,
    output logic        read_valid,
    output logic        stall,
    output logic        addr_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               wr_q;
    logic               rd_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic req;
    logic bad;
    logic accept;
    logic commit;

    // Request decode: misaligned or beyond the array is rejected outright.
    assign req    = mem_read_in | mem_write_in;
    assign bad    = (Mem_address[1:0] != 2'b00) || (Mem_address[31:IDX_W+2] != '0);
    assign accept = (state == IDLE) && req && !bad;
    assign commit = (state == BUSY) && (cnt == '0);

    assign stall      = accept || (state == BUSY);
    assign addr_error = (state == IDLE) && req && bad;

    // Control path, latched request and load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            Read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    read_valid <= 1'b0;
                    if (accept) begin
                        idx_q   <= Mem_address[IDX_W+1:2];
                        wdata_q <= Write_data_in;
                        // Both strobes high is treated as a store.
                        wr_q    <= mem_write_in;
                        rd_q    <= mem_read_in & ~mem_write_in;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= DONE;
                        if (rd_q) begin
                            Read_data  <= mem[idx_q];
                            read_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    read_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    read_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Storage array is not reset; reset forces IDLE asynchronously, so an
    // aborted store never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
